// File: rtl/cdb_channel_driver_pkg.sv
// Shared superscalar CDB definitions: channel tags and source-select type.
package cdb_channel_driver_pkg;

  localparam logic [1:0] CDB_TAG_ALU0 = 2'b00;
  localparam logic [1:0] CDB_TAG_ALU1 = 2'b01;
  localparam logic [1:0] CDB_TAG_ALU2 = 2'b10;
  localparam logic [1:0] CDB_TAG_LSQ  = 2'b11;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_sel_e;

  // Flip a source select.
  function automatic src_sel_e other_src(input src_sel_e s);
    return (s == SRC0) ? SRC1 : SRC0;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Result buffer: circular FIFO with two ordered write ports and one read port.
module cdb_result_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_a,
  input  logic [WIDTH-1:0]             data_a,
  input  logic                         push_b,
  input  logic [WIDTH-1:0]             data_b,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_b;
  logic [CNT_W-1:0] n_push;

  // Port b lands right after port a when both write, else at the tail.
  assign wr_ptr_b = wr_ptr + PTR_W'(push_a);
  assign n_push   = CNT_W'(push_a) + CNT_W'(push_b);
  assign rd_data  = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the buffer at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + n_push - CNT_W'(pop);
    end
  end

  // Entry storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= data_a;
    if (push_b) mem[wr_ptr_b] <= data_b;
  end

endmodule

// File: rtl/cdb_channel_driver.sv
// Merges two result sources into one backpressure-free CDB channel.
module cdb_channel_driver
  import cdb_channel_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned PHYS_REG_ADDR_WIDTH = 6,
  parameter int unsigned DEPTH               = 4,
  parameter logic [1:0]  CHANNEL_TAG         = CDB_TAG_LSQ
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           src0_valid,
  output logic                           src0_ready,
  input  logic [DATA_WIDTH-1:0]          src0_data,
  input  logic [PHYS_REG_ADDR_WIDTH-1:0] src0_dest_reg,
  input  logic                           src1_valid,
  output logic                           src1_ready,
  input  logic [DATA_WIDTH-1:0]          src1_data,
  input  logic [PHYS_REG_ADDR_WIDTH-1:0] src1_dest_reg,
  output logic                           cdb_valid,
  output logic [1:0]                     cdb_tag,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic [PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PHYS_REG_ADDR_WIDTH + DATA_WIDTH;

  src_sel_e           prio;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_slots;
  logic               acc0;
  logic               acc1;
  logic               push_a;
  logic               push_b;
  logic [ENTRY_W-1:0] data_a;
  logic [ENTRY_W-1:0] data_b;
  logic [ENTRY_W-1:0] rd_data;
  logic               prio_toggle;

  // Free space ignores the same-cycle pop so ready never depends on the CDB.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));

  // Ready arbitration: both when room for two, one by round-robin when room for one.
  always_comb begin
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    if (reset && !flush) begin
      if (free_slots >= CNT_W'(2)) begin
        src0_ready = 1'b1;
        src1_ready = 1'b1;
      end else if (free_slots == CNT_W'(1)) begin
        if (prio == SRC0) begin
          if (src0_valid) src0_ready = 1'b1;
          else            src1_ready = 1'b1;
        end else begin
          if (src1_valid) src1_ready = 1'b1;
          else            src0_ready = 1'b0 | 1'b1;
        end
      end
    end
  end

  assign acc0 = src0_valid & src0_ready;
  assign acc1 = src1_valid & src1_ready;

  // Priority source goes to write port a so it lands first in the buffer.
  always_comb begin
    push_a = acc0;
    push_b = acc1;
    data_a = {src0_dest_reg, src0_data};
    data_b = {src1_dest_reg, src1_data};
    if (prio == SRC1) begin
      push_a = acc1;
      push_b = acc0;
      data_a = {src1_dest_reg, src1_data};
      data_b = {src0_dest_reg, src0_data};
    end
  end

  assign prio_toggle = src0_valid & src1_valid & (src0_ready | src1_ready);

  // Round-robin pointer advances only after a contended cycle is resolved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= SRC0;
    end else if (prio_toggle) begin
      prio <= other_src(prio);
    end
  end

  cdb_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush   (flush),
    .push_a  (push_a),
    .data_a  (data_a),
    .push_b  (push_b),
    .data_b  (data_b),
    .pop     (!empty),
    .rd_data (rd_data),
    .count   (count)
  );

  // The head is broadcast every cycle the buffer holds anything.
  assign cdb_valid                  = !empty;
  assign cdb_tag                    = CHANNEL_TAG;
  assign {cdb_dest_reg, cdb_data}   = rd_data;

endmodule

// File: tb/tb_cdb_channel_driver.sv
// Directed bench for cdb_channel_driver; a DEPTH=2 instance covers the full case.
module tb_cdb_channel_driver;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        src0_valid, src0_ready, src1_valid, src1_ready;
  logic [31:0] src0_data, src1_data;
  logic [5:0]  src0_dest_reg, src1_dest_reg;
  logic        cdb_valid, full, empty;
  logic [1:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_dest_reg;

  logic        b_src0_valid, b_src0_ready, b_src1_valid, b_src1_ready;
  logic [31:0] b_src0_data, b_src1_data;
  logic [5:0]  b_src0_dest_reg, b_src1_dest_reg;
  logic        b_cdb_valid, b_full, b_empty;
  logic [1:0]  b_cdb_tag;
  logic [31:0] b_cdb_data;
  logic [5:0]  b_cdb_dest_reg;

  int errors = 0;
  int checks = 0;

  cdb_channel_driver dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src0_data(src0_data), .src0_dest_reg(src0_dest_reg),
    .src1_valid(src1_valid), .src1_ready(src1_ready),
    .src1_data(src1_data), .src1_dest_reg(src1_dest_reg),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_dest_reg(cdb_dest_reg), .full(full), .empty(empty)
  );

  cdb_channel_driver #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .src0_valid(b_src0_valid), .src0_ready(b_src0_ready),
    .src0_data(b_src0_data), .src0_dest_reg(b_src0_dest_reg),
    .src1_valid(b_src1_valid), .src1_ready(b_src1_ready),
    .src1_data(b_src1_data), .src1_dest_reg(b_src1_dest_reg),
    .cdb_valid(b_cdb_valid), .cdb_tag(b_cdb_tag), .cdb_data(b_cdb_data),
    .cdb_dest_reg(b_cdb_dest_reg), .full(b_full), .empty(b_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic [5:0] r0,
                       input logic v1, input logic [31:0] d1, input logic [5:0] r1);
    src0_valid = v0; src0_data = d0; src0_dest_reg = r0;
    src1_valid = v1; src1_data = d1; src1_dest_reg = r1;
  endtask

  task automatic drive_b(input logic v0, input logic [31:0] d0, input logic [5:0] r0,
                         input logic v1, input logic [31:0] d1, input logic [5:0] r1);
    b_src0_valid = v0; b_src0_data = d0; b_src0_dest_reg = r0;
    b_src1_valid = v1; b_src1_data = d1; b_src1_dest_reg = r1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    // Held in reset: everything quiet, readies forced low.
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready0", 64'(src0_ready), 64'd0);
    chk("rst_ready1", 64'(src1_ready), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_ready0", 64'(src0_ready), 64'd1);
    chk("post_rst_ready1", 64'(src1_ready), 64'd1);
    chk("post_rst_cdb_valid", 64'(cdb_valid), 64'd0);

    // Single push from source 0.
    drive(1, 32'hDEAD_BEEF, 6'd5, 0, 0, 0);
    #1 chk("t1_ready0", 64'(src0_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("t1_cdb_tag", 64'(cdb_tag), 64'd3);
    chk("t1_cdb_data", 64'(cdb_data), 64'hDEAD_BEEF);
    chk("t1_cdb_dest", 64'(cdb_dest_reg), 64'd5);
    tick();
    chk("t1_drained", 64'(cdb_valid), 64'd0);

    // Both sources into an empty buffer; source 0 broadcasts first.
    drive(1, 32'h11, 6'd1, 1, 32'h22, 6'd2);
    #1;
    chk("t2_ready0", 64'(src0_ready), 64'd1);
    chk("t2_ready1", 64'(src1_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_first_data", 64'(cdb_data), 64'h11);
    chk("t2_first_dest", 64'(cdb_dest_reg), 64'd1);
    tick();
    chk("t2_second_valid", 64'(cdb_valid), 64'd1);
    chk("t2_second_data", 64'(cdb_data), 64'h22);
    chk("t2_second_dest", 64'(cdb_dest_reg), 64'd2);
    tick();
    chk("t2_drained", 64'(cdb_valid), 64'd0);

    // Short reset pulse returns priority to source 0.
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;

    // Build up to 3 entries, then contend with one free slot.
    drive(1, 32'hA0, 6'd10, 1, 32'hA1, 6'd11);
    #1 chk("t3_a_cdb_valid", 64'(cdb_valid), 64'd0);
    tick();
    drive(1, 32'hB0, 6'd12, 1, 32'hB1, 6'd13);
    #1;
    chk("t3_b_ready0", 64'(src0_ready), 64'd1);
    chk("t3_b_ready1", 64'(src1_ready), 64'd1);
    chk("t3_b_head", 64'(cdb_data), 64'hA0);
    tick();
    drive(1, 32'hC0, 6'd14, 1, 32'hC1, 6'd15);
    #1;
    chk("t3_c1_ready0", 64'(src0_ready), 64'd1);
    chk("t3_c1_ready1", 64'(src1_ready), 64'd0);
    chk("t3_c1_head", 64'(cdb_data), 64'hA1);
    chk("t3_c1_full", 64'(full), 64'd0);
    tick();
    drive(1, 32'hD0, 6'd16, 1, 32'hC1, 6'd15);
    #1;
    chk("t3_c2_ready0", 64'(src0_ready), 64'd0);
    chk("t3_c2_ready1", 64'(src1_ready), 64'd1);
    chk("t3_c2_head", 64'(cdb_data), 64'hB1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("t3_drain_b0", 64'(cdb_data), 64'hB0);
    tick();
    chk("t3_drain_c0", 64'(cdb_data), 64'hC0);
    tick();
    chk("t3_drain_c1", 64'(cdb_data), 64'hC1);
    chk("t3_drain_c1_dest", 64'(cdb_dest_reg), 64'd15);
    tick();
    chk("t3_drained", 64'(cdb_valid), 64'd0);

    // DEPTH=2 instance: two pushes fill it, then one pop frees one slot.
    drive_b(1, 32'h01, 6'd1, 1, 32'h02, 6'd2);
    #1;
    chk("t4_ready0", 64'(b_src0_ready), 64'd1);
    chk("t4_ready1", 64'(b_src1_ready), 64'd1);
    tick();
    drive_b(1, 32'h03, 6'd3, 1, 32'h04, 6'd4);
    #1;
    chk("t4_full", 64'(b_full), 64'd1);
    chk("t4_full_ready0", 64'(b_src0_ready), 64'd0);
    chk("t4_full_ready1", 64'(b_src1_ready), 64'd0);
    chk("t4_full_head", 64'(b_cdb_data), 64'h01);
    tick();
    chk("t4_free1_full", 64'(b_full), 64'd0);
    chk("t4_free1_ready0", 64'(b_src0_ready), 64'd0);
    chk("t4_free1_ready1", 64'(b_src1_ready), 64'd1);
    chk("t4_free1_head", 64'(b_cdb_data), 64'h02);
    tick();
    drive_b(0, 0, 0, 0, 0, 0);
    #1 chk("t4_last_head", 64'(b_cdb_data), 64'h04);
    tick();
    chk("t4_empty", 64'(b_empty), 64'd1);

    // Flush with 3 entries while source 1 offers a result.
    drive(1, 32'hE0, 6'd20, 1, 32'hE1, 6'd21);
    tick();
    drive(1, 32'hF0, 6'd22, 1, 32'hF1, 6'd23);
    tick();
    drive(0, 0, 0, 1, 32'h99, 6'd9);
    flush = 1'b1;
    #1;
    chk("t5_flush_ready0", 64'(src0_ready), 64'd0);
    chk("t5_flush_ready1", 64'(src1_ready), 64'd0);
    chk("t5_flush_cdb_valid", 64'(cdb_valid), 64'd1);
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t5_after_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("t5_after_empty", 64'(empty), 64'd1);
    chk("t5_after_ready1", 64'(src1_ready), 64'd1);
    tick();
    chk("t5_no_sneak", 64'(cdb_valid), 64'd0);

    // Asynchronous reset with 2 entries buffered.
    drive(1, 32'h3030, 6'd30, 1, 32'h3131, 6'd31);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_pre_valid", 64'(cdb_valid), 64'd1);
    chk("t6_pre_head", 64'(cdb_data), 64'h3030);
    #1 reset = 1'b0;
    #1;
    chk("t6_async_valid", 64'(cdb_valid), 64'd0);
    chk("t6_async_empty", 64'(empty), 64'd1);
    chk("t6_async_ready0", 64'(src0_ready), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_release_valid", 64'(cdb_valid), 64'd0);
    tick();
    chk("t6_no_stale", 64'(cdb_valid), 64'd0);

    // After reset priority is source 0 again; dest 0 passes through untouched.
    drive(1, 32'h66, 6'd0, 1, 32'h77, 6'd3);
    #1;
    chk("t7_ready0", 64'(src0_ready), 64'd1);
    chk("t7_ready1", 64'(src1_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t7_first_data", 64'(cdb_data), 64'h66);
    chk("t7_first_dest0", 64'(cdb_dest_reg), 64'd0);
    chk("t7_first_valid", 64'(cdb_valid), 64'd1);
    tick();
    chk("t7_second_data", 64'(cdb_data), 64'h77);
    chk("t7_second_dest", 64'(cdb_dest_reg), 64'd3);
    tick();
    chk("t7_drained", 64'(cdb_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
